// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-side bundle: instruction-memory req/ack, F/D valid/ready delivery and
// the D-stage branch resolution inputs that steer the PC.
interface fetch_redirect_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        br_valid;
    logic [2:0]  br_type;
    logic        equal;
    logic        greater;
    logic        greater_or_equal;
    logic [31:0] br_target;
    logic        br_taken;

    modport master (
        output imem_req, imem_addr, f_valid, f_instr, f_pc, br_taken,
        input  imem_ack, imem_rdata, f_ready, br_valid, br_type,
               equal, greater, greater_or_equal, br_target
    );

    modport slave (
        input  imem_req, imem_addr, f_valid, f_instr, f_pc, br_taken,
        output imem_ack, imem_rdata, f_ready, br_valid, br_type,
               equal, greater, greater_or_equal, br_target
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// PC owner and req/ack fetch FSM; decodes branch conditions from the D-stage
// comparator flags and redirects fetch after the one-instruction delay slot.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic clk,
    input  logic reset,
    fetch_redirect_ctrl_if.master bus
);
    localparam logic [2:0] BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BGTZ = 3'd3,
                           BR_BLEZ = 3'd4, BR_BGEZ = 3'd5, BR_BLTZ = 3'd6, BR_JUMP = 3'd7;

    typedef enum logic {FETCH, DELIVER} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic        cond;
    logic        taken;
    logic        fetch_ack;

    always_comb begin
        cond = 1'b0;
        case (bus.br_type)
            BR_NONE: cond = 1'b0;
            BR_BEQ:  cond = bus.equal;
            BR_BNE:  cond = !bus.equal;
            BR_BGTZ: cond = bus.greater;
            BR_BLEZ: cond = !bus.greater;
            BR_BGEZ: cond = bus.greater_or_equal;
            BR_BLTZ: cond = !bus.greater_or_equal;
            BR_JUMP: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign taken     = bus.br_valid & cond;
    assign fetch_ack = (state_q == FETCH) & bus.imem_ack;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        fpc_d        = fpc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d      = bus.imem_rdata;
                    fpc_d        = pc_q;
                    state_d      = DELIVER;
                    redir_pend_d = 1'b0;
                    // A branch resolving on the delay-slot ack steers this very update.
                    if (taken)             pc_d = bus.br_target;
                    else if (redir_pend_q) pc_d = redir_pc_q;
                    else                   pc_d = pc_q + 32'd4;
                end
            end
            DELIVER: begin
                if (bus.f_ready) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Otherwise the delay slot is still ahead of us; remember the target.
        if (taken && !fetch_ack) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = bus.br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            fpc_q        <= '0;
            redir_pc_q   <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            fpc_q        <= fpc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    assign bus.imem_req  = (state_q == FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.f_valid   = (state_q == DELIVER);
    assign bus.f_instr   = instr_q;
    assign bus.f_pc      = fpc_q;
    assign bus.br_taken  = taken;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scenarios plus randomized traffic, all checked every cycle against a
// transaction-level model of the fetch stream held in the bench.
module tb_fetch_redirect_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if bus();
    fetch_redirect_ctrl #(.RESET_PC(RST_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch condition as a lookup table indexed by br_type.
    function automatic bit model_taken(bit v, logic [2:0] t, bit eq, bit gt, bit ge);
        bit tbl [8];
        tbl = '{1'b0, eq, !eq, gt, !gt, ge, !ge, 1'b1};
        return v && tbl[t];
    endfunction

    // Memory responder: ack after ack_wait cycles of request, or randomly.
    bit ack_en = 1'b1;
    bit rand_ack = 1'b0;
    int ack_wait = 1;
    int ack_cnt = 0;
    always @(posedge clk) begin
        #2;
        if (reset || !bus.imem_req || !ack_en) begin
            bus.imem_ack = 1'b0;
            ack_cnt = 0;
        end else if (rand_ack ? ($urandom_range(0, 1) == 1) : (ack_cnt >= ack_wait)) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = $urandom;
        end else begin
            bus.imem_ack = 1'b0;
            ack_cnt++;
        end
    end

    // Model: is a fetch outstanding, which address, the pending redirect, last delivery.
    bit          m_ok = 1'b0;
    bit          m_fetch;
    bit          m_pend;
    logic [31:0] m_pc, m_rpc, m_instr, m_fpc;

    always @(negedge clk) begin
        bit tk;
        logic [31:0] nxt;
        tk = model_taken(bus.br_valid, bus.br_type, bus.equal, bus.greater, bus.greater_or_equal);
        if (m_ok) begin
            check("m_br_taken", {31'd0, bus.br_taken}, {31'd0, tk});
            check("m_imem_req", {31'd0, bus.imem_req}, {31'd0, m_fetch});
            check("m_f_valid", {31'd0, bus.f_valid}, {31'd0, !m_fetch});
            if (m_fetch) check("m_imem_addr", bus.imem_addr, m_pc);
            check("m_f_instr", bus.f_instr, m_instr);
            check("m_f_pc", bus.f_pc, m_fpc);
        end
        if (reset) begin
            m_ok = 1'b1; m_fetch = 1'b1; m_pc = RST_PC; m_pend = 1'b0;
            m_rpc = '0; m_instr = '0; m_fpc = '0;
        end else if (m_ok) begin
            if (m_fetch && bus.imem_ack) begin
                nxt = tk ? bus.br_target : (m_pend ? m_rpc : m_pc + 32'd4);
                m_instr = bus.imem_rdata;
                m_fpc = m_pc;
                m_pc = nxt;
                m_pend = 1'b0;
                m_fetch = 1'b0;
            end else begin
                if (tk) begin m_pend = 1'b1; m_rpc = bus.br_target; end
                if (!m_fetch && bus.f_ready) m_fetch = 1'b1;
            end
        end
    end

    task automatic clear_br();
        bus.br_valid = 1'b0; bus.br_type = 3'd0; bus.equal = 1'b0;
        bus.greater = 1'b0; bus.greater_or_equal = 1'b0; bus.br_target = '0;
    endtask

    task automatic set_br(input logic [2:0] t, input bit eq, input bit gt, input bit ge,
                          input logic [31:0] tgt);
        bus.br_valid = 1'b1; bus.br_type = t; bus.equal = eq;
        bus.greater = gt; bus.greater_or_equal = ge; bus.br_target = tgt;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        clear_br();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Wait for the next ack, check its address, then the delivery that follows.
    task automatic fetch_one(input string n, input logic [31:0] exp);
        bit got = 1'b0;
        logic [31:0] d;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_ack) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no ack for expected addr %h", n, exp);
            return;
        end
        check({n, "_addr"}, bus.imem_addr, exp);
        d = bus.imem_rdata;
        @(negedge clk);
        check({n, "_fvalid"}, {31'd0, bus.f_valid}, 32'd1);
        check({n, "_fpc"}, bus.f_pc, exp);
        check({n, "_finstr"}, bus.f_instr, d);
    endtask

    initial begin
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.f_ready = 1'b1;
        clear_br();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, bus.imem_req}, 32'd1);
        check("rst_addr", bus.imem_addr, 32'h3000);
        check("rst_fvalid", {31'd0, bus.f_valid}, 32'd0);
        check("rst_finstr", bus.f_instr, 32'd0);
        check("rst_fpc", bus.f_pc, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // T1: sequential fetch, one delivery cycle each
        fetch_one("t1_a0", 32'h3000);
        fetch_one("t1_a1", 32'h3004);
        fetch_one("t1_a2", 32'h3008);
        @(negedge clk);
        check("t1_fvalid_low", {31'd0, bus.f_valid}, 32'd0);

        // T2: taken BEQ resolves before delay-slot ack, so target is pended
        reset_dut();
        fetch_one("t2_a0", 32'h3000);
        @(posedge clk); #1 set_br(3'd1, 1'b1, 1'b0, 1'b0, 32'h3100);
        @(negedge clk);
        check("t2_taken", {31'd0, bus.br_taken}, 32'd1);
        @(posedge clk); #1 clear_br();
        fetch_one("t2_a1", 32'h3004);
        fetch_one("t2_a2", 32'h3100);

        // T3: BNE with equal=1 is not taken
        reset_dut();
        fetch_one("t3_a0", 32'h3000);
        @(posedge clk); #1 set_br(3'd2, 1'b1, 1'b0, 1'b0, 32'h3100);
        @(negedge clk);
        check("t3_taken", {31'd0, bus.br_taken}, 32'd0);
        @(posedge clk); #1 clear_br();
        fetch_one("t3_a1", 32'h3004);
        fetch_one("t3_a2", 32'h3008);

        // T4: BLTZ coincident with the delay-slot ack uses the target directly
        reset_dut();
        ack_wait = 0;
        fetch_one("t4_a0", 32'h3000);
        @(posedge clk); #1 set_br(3'd6, 1'b0, 1'b0, 1'b0, 32'h3200);
        @(negedge clk);
        check("t4_taken", {31'd0, bus.br_taken}, 32'd1);
        check("t4_ack", {31'd0, bus.imem_ack}, 32'd1);
        check("t4_addr", bus.imem_addr, 32'h3004);
        @(posedge clk); #1 clear_br();
        @(negedge clk);
        check("t4_fpc", bus.f_pc, 32'h3004);
        check("t4_model_pend", {31'd0, m_pend}, 32'd0);
        fetch_one("t4_a2", 32'h3200);
        fetch_one("t4_a3", 32'h3204);
        ack_wait = 1;

        // T5: three-cycle stall in DELIVER holds everything
        reset_dut();
        fetch_one("t5_a0", 32'h3000);
        begin
            logic [31:0] d5;
            bit got5 = 1'b0;
            for (int i = 0; i < 50 && !got5; i++) begin
                @(negedge clk);
                if (bus.imem_req && bus.imem_ack) got5 = 1'b1;
            end
            check("t5_addr", bus.imem_addr, 32'h3004);
            d5 = bus.imem_rdata;
            @(posedge clk); #1 bus.f_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("t5_stall_fvalid", {31'd0, bus.f_valid}, 32'd1);
                check("t5_stall_finstr", bus.f_instr, d5);
                check("t5_stall_fpc", bus.f_pc, 32'h3004);
                check("t5_stall_req", {31'd0, bus.imem_req}, 32'd0);
                @(posedge clk); #1;
            end
            bus.f_ready = 1'b1;
            @(negedge clk);
            check("t5_xfer_fvalid", {31'd0, bus.f_valid}, 32'd1);
            fetch_one("t5_a2", 32'h3008);
        end

        // T6: reset mid-FETCH with a pending redirect and ack held off
        reset_dut();
        fetch_one("t6_a0", 32'h3000);
        @(posedge clk); #1 set_br(3'd7, 1'b0, 1'b0, 1'b0, 32'h3100);
        @(posedge clk); #1 clear_br();
        fetch_one("t6_a1", 32'h3004);
        fetch_one("t6_a2", 32'h3100);
        ack_en = 1'b0;
        @(posedge clk); #1 set_br(3'd7, 1'b0, 1'b0, 1'b0, 32'h3400);
        @(negedge clk);
        check("t6_addr_held", bus.imem_addr, 32'h3104);
        @(posedge clk); #1 clear_br(); reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_rst_addr", bus.imem_addr, 32'h3000);
        check("t6_rst_fvalid", {31'd0, bus.f_valid}, 32'd0);
        check("t6_rst_req", {31'd0, bus.imem_req}, 32'd1);
        @(posedge clk); #1 reset = 1'b0; ack_en = 1'b1;
        fetch_one("t6_a3", 32'h3000);
        fetch_one("t6_a4", 32'h3004);

        // Randomized traffic; the per-cycle model compare does the checking
        reset_dut();
        rand_ack = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            bus.f_ready = ($urandom_range(0, 9) < 7);
            bus.br_valid = ($urandom_range(0, 4) == 0);
            bus.br_type = 3'($urandom_range(0, 7));
            bus.equal = 1'($urandom);
            bus.greater = 1'($urandom);
            bus.greater_or_equal = 1'($urandom);
            bus.br_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        end
        @(posedge clk); #1 reset = 1'b0; clear_br();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
